// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the decode/execute boundary.
// Holds the default datapath widths, the "no memory access" codes and a
// packed control bundle with its all-zero (bubble) value. The hazard logic
// and the ID/EX register both draw on these so a bubble means the same
// thing everywhere.
package pipe_pkg;

  localparam int DATA_W   = 32;
  localparam int RAW_W    = 5;
  localparam int ALUCTR_W = 5;

  localparam logic [2:0] MEMREAD_NONE  = 3'd0;
  localparam logic [1:0] MEMWRITE_NONE = 2'd0;

  typedef struct packed {
    logic                regdst;
    logic                alusrc;
    logic [ALUCTR_W-1:0] aluctr;
    logic                memtoreg;
    logic                regwrite;
    logic [1:0]          memwrite;
    logic [2:0]          memread;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '{
    regdst:   1'b0,
    alusrc:   1'b0,
    aluctr:   '0,
    memtoreg: 1'b0,
    regwrite: 1'b0,
    memwrite: MEMWRITE_NONE,
    memread:  MEMREAD_NONE
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags a decode-stage instruction that reads a register which the load
// currently in execute has not yet produced. Loads always write rt, and a
// load into r0 never creates a dependency.
// Ports:
//   i_ex_valid, i_ex_regwrite, i_ex_memread, i_ex_rt : execute-stage entry
//   i_id_valid, i_id_use_rs, i_id_use_rt             : decode-stage qualifiers
//   i_id_rs, i_id_rt                                 : decode-stage sources
//   o_load_use                                       : hazard present
module load_use_detect
  import pipe_pkg::MEMREAD_NONE;
#(
  parameter int RAW_W = pipe_pkg::RAW_W
) (
  input  logic             i_ex_valid,
  input  logic             i_ex_regwrite,
  input  logic [2:0]       i_ex_memread,
  input  logic [RAW_W-1:0] i_ex_rt,
  input  logic             i_id_valid,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic [RAW_W-1:0] i_id_rs,
  input  logic [RAW_W-1:0] i_id_rt,
  output logic             o_load_use
);

  logic w_ex_is_load;
  logic w_src_match;

  assign w_ex_is_load = i_ex_valid & i_ex_regwrite & (i_ex_memread != MEMREAD_NONE)
                      & (i_ex_rt != '0);
  assign w_src_match  = (i_id_use_rs & (i_id_rs == i_ex_rt))
                      | (i_id_use_rt & (i_id_rt == i_ex_rt));
  assign o_load_use   = w_ex_is_load & i_id_valid & w_src_match;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid bit, hold, branch flush and internal
// load-use bubble insertion.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   flush             : squash the decode-stage instruction (wins over hold)
//   hold              : downstream stall, freeze contents
//   id_*              : decode-stage instruction, control, operands, fields
//   ex_*              : registered copies presented to execute
//   stall_o           : combinational request to hold PC and IF/ID
//   bubble_cnt        : saturating count of load-use bubbles since reset
// A bubble clears the whole entry, so downstream sees regwrite/memwrite/
// memread all zero. Entries captured with id_valid=0 still carry their
// fields; every side effect downstream must be qualified with ex_valid.
module idex_pipe_reg #(
  parameter int DATA_W   = pipe_pkg::DATA_W,
  parameter int RAW_W    = pipe_pkg::RAW_W,
  parameter int ALUCTR_W = pipe_pkg::ALUCTR_W,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                hold,
  input  logic                id_valid,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                id_regdst,
  input  logic                id_alusrc,
  input  logic                id_memtoreg,
  input  logic                id_regwrite,
  input  logic [ALUCTR_W-1:0] id_aluctr,
  input  logic [1:0]          id_memwrite,
  input  logic [2:0]          id_memread,
  input  logic [DATA_W-1:0]   id_rdata1,
  input  logic [DATA_W-1:0]   id_rdata2,
  input  logic [DATA_W-1:0]   id_ext32,
  input  logic [RAW_W-1:0]    id_rs,
  input  logic [RAW_W-1:0]    id_rt,
  input  logic [RAW_W-1:0]    id_rd,
  input  logic [RAW_W-1:0]    id_sa,
  output logic                ex_valid,
  output logic                ex_regdst,
  output logic                ex_alusrc,
  output logic                ex_memtoreg,
  output logic                ex_regwrite,
  output logic [ALUCTR_W-1:0] ex_aluctr,
  output logic [1:0]          ex_memwrite,
  output logic [2:0]          ex_memread,
  output logic [DATA_W-1:0]   ex_rdata1,
  output logic [DATA_W-1:0]   ex_rdata2,
  output logic [DATA_W-1:0]   ex_ext32,
  output logic [RAW_W-1:0]    ex_rs,
  output logic [RAW_W-1:0]    ex_rt,
  output logic [RAW_W-1:0]    ex_rd,
  output logic [RAW_W-1:0]    ex_sa,
  output logic                stall_o,
  output logic [CNT_W-1:0]    bubble_cnt
);

  typedef struct packed {
    logic                valid;
    logic                regdst;
    logic                alusrc;
    logic                memtoreg;
    logic                regwrite;
    logic [ALUCTR_W-1:0] aluctr;
    logic [1:0]          memwrite;
    logic [2:0]          memread;
    logic [DATA_W-1:0]   rdata1;
    logic [DATA_W-1:0]   rdata2;
    logic [DATA_W-1:0]   ext32;
    logic [RAW_W-1:0]    rs;
    logic [RAW_W-1:0]    rt;
    logic [RAW_W-1:0]    rd;
    logic [RAW_W-1:0]    sa;
  } entry_t;

  entry_t            r_ex_p1;
  logic [CNT_W-1:0]  r_bubble_cnt_p1;
  entry_t            w_id_p0;
  entry_t            w_bubble;
  logic              w_load_use;

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_id_p0 = '{
    valid:    id_valid,
    regdst:   id_regdst,
    alusrc:   id_alusrc,
    memtoreg: id_memtoreg,
    regwrite: id_regwrite,
    aluctr:   id_aluctr,
    memwrite: id_memwrite,
    memread:  id_memread,
    rdata1:   id_rdata1,
    rdata2:   id_rdata2,
    ext32:    id_ext32,
    rs:       id_rs,
    rt:       id_rt,
    rd:       id_rd,
    sa:       id_sa
  };

  // Bubble: invalid, every control bit at its no-op value, data zeroed.
  always_comb begin
    w_bubble          = '0;
    w_bubble.regdst   = pipe_pkg::CTRL_ZERO.regdst;
    w_bubble.alusrc   = pipe_pkg::CTRL_ZERO.alusrc;
    w_bubble.aluctr   = ALUCTR_W'(pipe_pkg::CTRL_ZERO.aluctr);
    w_bubble.memtoreg = pipe_pkg::CTRL_ZERO.memtoreg;
    w_bubble.regwrite = pipe_pkg::CTRL_ZERO.regwrite;
    w_bubble.memwrite = pipe_pkg::CTRL_ZERO.memwrite;
    w_bubble.memread  = pipe_pkg::CTRL_ZERO.memread;
  end

  load_use_detect #(
    .RAW_W(RAW_W)
  ) u_load_use_detect (
    .i_ex_valid    (r_ex_p1.valid),
    .i_ex_regwrite (r_ex_p1.regwrite),
    .i_ex_memread  (r_ex_p1.memread),
    .i_ex_rt       (r_ex_p1.rt),
    .i_id_valid    (id_valid),
    .i_id_use_rs   (id_use_rs),
    .i_id_use_rt   (id_use_rt),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .o_load_use    (w_load_use)
  );

  // A flushed decode instruction is being discarded, so it cannot need a stall.
  assign stall_o = hold | (w_load_use & ~flush);

  // ---- stage p0 (decode inputs) -> p1 (execute entry) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_p1         <= '0;
      r_bubble_cnt_p1 <= '0;
    end else if (flush) begin
      r_ex_p1 <= w_bubble;
    end else if (!hold) begin
      if (w_load_use) begin
        r_ex_p1         <= w_bubble;
        r_bubble_cnt_p1 <= sat_inc(r_bubble_cnt_p1);
      end else begin
        r_ex_p1 <= w_id_p0;
      end
    end
  end

  assign ex_valid    = r_ex_p1.valid;
  assign ex_regdst   = r_ex_p1.regdst;
  assign ex_alusrc   = r_ex_p1.alusrc;
  assign ex_memtoreg = r_ex_p1.memtoreg;
  assign ex_regwrite = r_ex_p1.regwrite;
  assign ex_aluctr   = r_ex_p1.aluctr;
  assign ex_memwrite = r_ex_p1.memwrite;
  assign ex_memread  = r_ex_p1.memread;
  assign ex_rdata1   = r_ex_p1.rdata1;
  assign ex_rdata2   = r_ex_p1.rdata2;
  assign ex_ext32    = r_ex_p1.ext32;
  assign ex_rs       = r_ex_p1.rs;
  assign ex_rt       = r_ex_p1.rt;
  assign ex_rd       = r_ex_p1.rd;
  assign ex_sa       = r_ex_p1.sa;
  assign bubble_cnt  = r_bubble_cnt_p1;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Scoreboard bench for idex_pipe_reg. Each driven cycle pushes the expected
// pre-edge stall_o and post-edge register contents / bubble count; a monitor
// pops and compares. Bubble counter is 2 bits wide to reach saturation.
module tb_idex_pipe_reg;

  typedef struct packed {
    logic        valid, use_rs, use_rt, regdst, alusrc, memtoreg, regwrite;
    logic [4:0]  aluctr;
    logic [1:0]  memwrite;
    logic [2:0]  memread;
    logic [31:0] rdata1, rdata2, ext32;
    logic [4:0]  rs, rt, rd, sa;
  } id_t;

  typedef struct packed {
    logic        valid, regdst, alusrc, memtoreg, regwrite;
    logic [4:0]  aluctr;
    logic [1:0]  memwrite;
    logic [2:0]  memread;
    logic [31:0] rdata1, rdata2, ext32;
    logic [4:0]  rs, rt, rd, sa;
  } ex_t;

  typedef struct {
    int         idx;
    logic       stall;
    ex_t        ex;
    logic [1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0, flush = 1'b0, hold = 1'b0;
  id_t  cur = '0;

  logic        ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite;
  logic [4:0]  ex_aluctr;
  logic [1:0]  ex_memwrite;
  logic [2:0]  ex_memread;
  logic [31:0] ex_rdata1, ex_rdata2, ex_ext32;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_sa;
  logic        stall_o;
  logic [1:0]  bubble_cnt;
  ex_t         ex_now;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  idex_pipe_reg #(.DATA_W(32), .RAW_W(5), .ALUCTR_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .hold(hold),
    .id_valid(cur.valid), .id_use_rs(cur.use_rs), .id_use_rt(cur.use_rt),
    .id_regdst(cur.regdst), .id_alusrc(cur.alusrc), .id_memtoreg(cur.memtoreg),
    .id_regwrite(cur.regwrite), .id_aluctr(cur.aluctr), .id_memwrite(cur.memwrite),
    .id_memread(cur.memread), .id_rdata1(cur.rdata1), .id_rdata2(cur.rdata2),
    .id_ext32(cur.ext32), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd), .id_sa(cur.sa),
    .ex_valid(ex_valid), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .ex_aluctr(ex_aluctr),
    .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_ext32(ex_ext32), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_sa(ex_sa), .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  assign ex_now = '{ex_valid, ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_aluctr,
                    ex_memwrite, ex_memread, ex_rdata1, ex_rdata2, ex_ext32,
                    ex_rs, ex_rt, ex_rd, ex_sa};

  function automatic id_t mk_alu(input logic [4:0] rs, rt, rd, input logic [31:0] d1, d2);
    id_t v = '0;
    v.valid = 1'b1; v.use_rs = 1'b1; v.use_rt = 1'b1;
    v.regdst = 1'b1; v.regwrite = 1'b1; v.aluctr = 5'd2;
    v.rdata1 = d1; v.rdata2 = d2; v.rs = rs; v.rt = rt; v.rd = rd; v.sa = 5'd3;
    return v;
  endfunction

  function automatic id_t mk_lw(input logic [4:0] rs, rt, input logic [31:0] imm);
    id_t v = '0;
    v.valid = 1'b1; v.use_rs = 1'b1; v.alusrc = 1'b1; v.memtoreg = 1'b1;
    v.regwrite = 1'b1; v.aluctr = 5'd2; v.memread = 3'd1;
    v.rdata1 = 32'h0000_0100; v.ext32 = imm; v.rs = rs; v.rt = rt;
    return v;
  endfunction

  function automatic ex_t to_ex(input id_t v);
    return '{v.valid, v.regdst, v.alusrc, v.memtoreg, v.regwrite, v.aluctr, v.memwrite,
             v.memread, v.rdata1, v.rdata2, v.ext32, v.rs, v.rt, v.rd, v.sa};
  endfunction

  int row = 0;

  task automatic drive(input id_t id, input logic r, f, h,
                       input logic e_stall, input ex_t e_ex, input logic [1:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #2;
    cur = id; rst = r; flush = f; hold = h;
    e.idx = row; e.stall = e_stall; e.ex = e_ex; e.cnt = e_cnt;
    sb.push_back(e);
    row++;
  endtask

  // Monitor: stall_o checked mid-cycle, registers checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb[0];
        checks++;
        if (stall_o !== e.stall) begin
          errors++;
          $display("FAIL stall_o row %0d got=%b exp=%b", e.idx, stall_o, e.stall);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (ex_now !== e.ex) begin
          errors++;
          $display("FAIL ex_regs row %0d got=%h exp=%h", e.idx, ex_now, e.ex);
        end
        checks++;
        if (bubble_cnt !== e.cnt) begin
          errors++;
          $display("FAIL bubble_cnt row %0d got=%0d exp=%0d", e.idx, bubble_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    id_t nop, a, a_inv, l, c, l0, c0, l5, n, r5, c5, f, h1, h2, h3, h4, h5;
    ex_t bub;
    bub   = '0;
    nop   = '0;
    a     = mk_alu(5'd1, 5'd2, 5'd3, 32'h11, 32'h22);
    l     = mk_lw(5'd1, 5'd5, 32'h4);
    c     = mk_alu(5'd5, 5'd6, 5'd7, 32'h33, 32'h44);
    l0    = mk_lw(5'd2, 5'd0, 32'h8);
    c0    = mk_alu(5'd0, 5'd3, 5'd4, 32'h55, 32'h66);
    l5    = mk_lw(5'd2, 5'd5, 32'hC);
    n     = mk_alu(5'd5, 5'd9, 5'd8, 32'h77, 32'h88);
    n.use_rs = 1'b0;
    r5    = mk_alu(5'd1, 5'd5, 5'd5, 32'h99, 32'hAA);
    c5    = mk_alu(5'd5, 5'd5, 5'd6, 32'hBB, 32'hCC);
    f     = mk_alu(5'd1, 5'd2, 5'd10, 32'hDEAD, 32'hBEEF);
    h1    = mk_alu(5'd11, 5'd12, 5'd13, 32'h1001, 32'h2001);
    h2    = mk_alu(5'd14, 5'd15, 5'd16, 32'h1002, 32'h2002);
    h3    = mk_alu(5'd17, 5'd18, 5'd19, 32'h1003, 32'h2003);
    h4    = mk_alu(5'd20, 5'd21, 5'd22, 32'h1004, 32'h2004);
    h5    = mk_alu(5'd23, 5'd24, 5'd25, 32'h1005, 32'h2005);
    a_inv = a;
    a_inv.valid = 1'b0;

    //    id     rst   flush hold  stall exp_ex      cnt
    drive(nop,   1'b1, 1'b0, 1'b0, 1'b0, bub,        2'd0); // reset
    drive(a,     1'b0, 1'b0, 1'b0, 1'b0, to_ex(a),   2'd0); // plain flow
    drive(l,     1'b0, 1'b0, 1'b0, 1'b0, to_ex(l),   2'd0);
    drive(c,     1'b0, 1'b0, 1'b0, 1'b1, bub,        2'd1); // load-use bubble
    drive(c,     1'b0, 1'b0, 1'b0, 1'b0, to_ex(c),   2'd1); // consumer enters
    drive(l0,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l0),  2'd1);
    drive(c0,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(c0),  2'd1); // load into r0
    drive(l5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l5),  2'd1);
    drive(n,     1'b0, 1'b0, 1'b0, 1'b0, to_ex(n),   2'd1); // rs match but unused
    drive(r5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(r5),  2'd1);
    drive(c5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(c5),  2'd1); // non-load producer
    drive(f,     1'b0, 1'b1, 1'b1, 1'b1, bub,        2'd1); // flush beats hold
    drive(h1,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(h1),  2'd1);
    drive(h2,    1'b0, 1'b0, 1'b1, 1'b1, to_ex(h1),  2'd1); // hold x3
    drive(h3,    1'b0, 1'b0, 1'b1, 1'b1, to_ex(h1),  2'd1);
    drive(h4,    1'b0, 1'b0, 1'b1, 1'b1, to_ex(h1),  2'd1);
    drive(h5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(h5),  2'd1); // release
    drive(l5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l5),  2'd1);
    drive(c,     1'b0, 1'b1, 1'b0, 1'b0, bub,        2'd1); // flush masks hazard
    drive(l5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l5),  2'd1);
    drive(c,     1'b0, 1'b0, 1'b0, 1'b1, bub,        2'd2);
    drive(l5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l5),  2'd2);
    drive(c,     1'b0, 1'b0, 1'b0, 1'b1, bub,        2'd3);
    drive(l5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l5),  2'd3);
    drive(c,     1'b0, 1'b0, 1'b0, 1'b1, bub,        2'd3); // saturated
    drive(l5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l5),  2'd3);
    drive(c,     1'b0, 1'b0, 1'b0, 1'b1, bub,        2'd3);
    drive(l5,    1'b0, 1'b0, 1'b0, 1'b0, to_ex(l5),  2'd3);
    drive(c,     1'b1, 1'b0, 1'b0, 1'b1, bub,        2'd0); // reset mid-stall
    drive(c,     1'b0, 1'b0, 1'b0, 1'b0, to_ex(c),   2'd0);
    drive(a_inv, 1'b0, 1'b0, 1'b0, 1'b0, to_ex(a_inv), 2'd0); // invalid still captured

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
